// File: rtl/pinwheel_console.sv
// Console output device on the pinwheel data bus.
// Decodes one address tag, queues stored bytes in a FIFO and drains them over a
// valid/ready byte stream. Status and TX counter reads return with 1-cycle latency;
// bus_rdata is zero when not selected so several instances can be ORed together.
// Build option: define PINWHEEL_CONSOLE_CRLF_EN to expand each pushed 0x0A into 0x0D,0x0A.
module pinwheel_console #(
   parameter logic [3:0]  CONSOLE_TAG = 4'h4,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic        clock,
   input  logic        tick_reset_in,
   input  logic [31:0] bus_addr,
   input  logic        bus_rden,
   input  logic [31:0] bus_wdata,
   input  logic [3:0]  bus_wmask,
   input  logic        bus_wren,
   output logic [31:0] bus_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned FW = CW + 1;
   localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

   localparam logic [1:0] RegData   = 2'd0;
   localparam logic [1:0] RegStatus = 2'd1;
   localparam logic [1:0] RegCtrl   = 2'd2;
   localparam logic [1:0] RegTxCnt  = 2'd3;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   txcount_q, txcount_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          sel;
   logic [1:0]    reg_idx;
   logic          wr_data, wr_ctrl, wr_txc;
   logic          flush, clr_ovf;
   logic          pop, push_ok, ovf_evt;
   logic          full, empty;
   logic [FW-1:0] free_slots;
   logic [1:0]    need;
   logic [7:0]    first_byte;
   logic [31:0]   status;

   // Address bits outside the tag and register index are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{bus_addr[27:4], bus_addr[1:0], bus_wdata[31:8]};

   // Bus decode and FIFO push/pop qualification.
   always_comb begin
      sel     = (bus_addr[31:28] == CONSOLE_TAG);
      reg_idx = bus_addr[3:2];
      wr_data = sel & bus_wren & (reg_idx == RegData) & (|bus_wmask);
      wr_ctrl = sel & bus_wren & (reg_idx == RegCtrl);
      wr_txc  = sel & bus_wren & (reg_idx == RegTxCnt);
      flush   = wr_ctrl & bus_wdata[1];
      clr_ovf = wr_ctrl & bus_wdata[0];

      empty    = (count_q == '0);
      full     = (count_q == DepthC);
      tx_valid = ~empty;
      tx_data  = mem_q[rd_ptr_q];
      pop      = tx_valid & tx_ready;

      // A same-cycle pop frees one slot for the incoming byte(s).
      free_slots = FW'(DepthC - count_q) + FW'(pop);

`ifdef PINWHEEL_CONSOLE_CRLF_EN
      if (bus_wdata[7:0] == 8'h0A) begin
         need       = 2'd2;
         first_byte = 8'h0D;
      end else begin
         need       = 2'd1;
         first_byte = bus_wdata[7:0];
      end
`else
      need       = 2'd1;
      first_byte = bus_wdata[7:0];
`endif

      // Flush wins over any push, and a push dropped by flush is not an overflow.
      push_ok = wr_data & ~flush & (free_slots >= FW'(need));
      ovf_evt = wr_data & ~flush & ~push_ok;
   end

   // Next-state for pointers, count, overflow flag and handshake counter.
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      txcount_d = txcount_q + 32'(pop);
      ovf_d     = (ovf_q & ~clr_ovf) | ovf_evt;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(need);
            count_d  = count_q + CW'(need) - CW'(pop);
         end else begin
            count_d  = count_q - CW'(pop);
         end
      end

      if (wr_txc) begin
         txcount_d = '0;
      end
   end

   // Registered read data; reflects state before this cycle's updates.
   always_comb begin
      status  = {16'h0, 8'(count_q), 5'h0, ovf_q, full, empty};
      rdata_d = '0;
      if (sel & bus_rden) begin
         unique case (reg_idx)
            RegStatus: rdata_d = status;
            RegTxCnt:  rdata_d = txcount_q;
            default:   rdata_d = '0;
         endcase
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clock or posedge tick_reset_in) begin
      if (tick_reset_in) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         txcount_q <= '0;
         rdata_q   <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         txcount_q <= txcount_d;
         rdata_q   <= rdata_d;
      end
   end

   // FIFO storage; deliberately not reset.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= first_byte;
`ifdef PINWHEEL_CONSOLE_CRLF_EN
         if (need == 2'd2) begin
            mem_q[wr_ptr_q + AW'(1)] <= 8'h0A;
         end
`endif
      end
   end

   assign bus_rdata = rdata_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pinwheel_console.sv
// Self-checking bench for pinwheel_console: directed scenarios plus randomized
// bus/sink traffic, compared against a queue-based model of the console.
module tb_pinwheel_console;

   localparam int unsigned Depth = 16;

   logic        clock = 1'b0;
   logic        tick_reset_in = 1'b1;
   logic [31:0] bus_addr = '0;
   logic        bus_rden = 1'b0;
   logic [31:0] bus_wdata = '0;
   logic [3:0]  bus_wmask = '0;
   logic        bus_wren = 1'b0;
   logic [31:0] bus_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        overflow;

   always #5 clock = ~clock;

   pinwheel_console #(
      .CONSOLE_TAG (4'h4),
      .FIFO_DEPTH  (Depth)
   ) dut (
      .clock         (clock),
      .tick_reset_in (tick_reset_in),
      .bus_addr      (bus_addr),
      .bus_rden      (bus_rden),
      .bus_wdata     (bus_wdata),
      .bus_wmask     (bus_wmask),
      .bus_wren      (bus_wren),
      .bus_rdata     (bus_rdata),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .overflow      (overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: queued bytes, sticky overflow, handshake count.
   byte unsigned mq[$];
   bit           m_ovf = 1'b0;
   logic [31:0]  m_txc = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock with the current inputs, updating the model and checking outputs.
   task automatic step();
      logic [31:0]  rexp;
      logic         sel;
      logic [1:0]   idx;
      bit           pop, evt, clr;
      byte unsigned nb[$];
      sel  = (bus_addr[31:28] == 4'h4);
      idx  = bus_addr[3:2];
      rexp = '0;
      if (sel && bus_rden) begin
         if (idx == 2'd1) begin
            rexp = {16'h0, 8'(mq.size()), 5'h0, m_ovf, mq.size() == Depth, mq.size() == 0};
         end else if (idx == 2'd3) begin
            rexp = m_txc;
         end
      end
      pop = (mq.size() != 0) && tx_ready;
      if (pop) begin
         mq.delete(0);
         m_txc++;
      end
      evt = 1'b0;
      clr = 1'b0;
      if (sel && bus_wren) begin
         if (idx == 2'd0 && bus_wmask != 4'h0) begin
`ifdef PINWHEEL_CONSOLE_CRLF_EN
            if (bus_wdata[7:0] == 8'h0A) nb = '{8'h0D, 8'h0A};
            else nb = '{bus_wdata[7:0]};
`else
            nb = '{bus_wdata[7:0]};
`endif
            if (mq.size() + nb.size() <= Depth) begin
               foreach (nb[i]) mq.push_back(nb[i]);
            end else begin
               evt = 1'b1;
            end
         end else if (idx == 2'd2) begin
            clr = bus_wdata[0];
            if (bus_wdata[1]) mq.delete();
         end else if (idx == 2'd3) begin
            m_txc = '0;
         end
      end
      m_ovf = (m_ovf && !clr) || evt;
      @(posedge clock);
      #1;
      check("rdata", bus_rdata, rexp);
      check("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("tx_data", 32'(tx_data), 32'(mq[0]));
      check("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic idle();
      bus_rden  = 1'b0;
      bus_wren  = 1'b0;
      bus_wmask = 4'h0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus_addr  = a;
      bus_wdata = d;
      bus_wmask = 4'h1 << a[1:0];
      bus_wren  = 1'b1;
      bus_rden  = 1'b0;
      step();
      idle();
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      bus_addr = a;
      bus_rden = 1'b1;
      bus_wren = 1'b0;
      step();
      v = bus_rdata;
      idle();
   endtask

   task automatic idle_steps(input int n);
      idle();
      for (int i = 0; i < n; i++) step();
   endtask

   // Assert reset between clock edges and confirm outputs drop without an edge.
   task automatic do_reset();
      #2;
      tick_reset_in = 1'b1;
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_rdata", bus_rdata, 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      mq.delete();
      m_ovf = 1'b0;
      m_txc = '0;
      @(negedge clock);
      tick_reset_in = 1'b0;
      tx_ready = 1'b0;
      idle();
   endtask

   logic [31:0] v;

   initial begin
      idle();
      #1;
      check("init_rst_tx_valid", 32'(tx_valid), 32'h0);
      check("init_rst_rdata", bus_rdata, 32'h0);
      @(negedge clock);
      tick_reset_in = 1'b0;

      // Single byte and status read.
      wr(32'h4000_0000, 32'h0000_0048);
      check("h_tx_data", 32'(tx_data), 32'h48);
      rd(32'h4000_0004, v);
      check("h_status", v, 32'h0000_0100);

      // Overfill: 17th byte dropped, drain order, TX count.
      do_reset();
      for (int i = 0; i < 17; i++) wr(32'h4000_0000 | 32'(i % 4), 32'(i));
      rd(32'h4abc_0004, v);
      check("full_status", v, 32'h0000_1006);
      tx_ready = 1'b1;
      idle_steps(16);
      tx_ready = 1'b0;
      rd(32'h4000_000C, v);
      check("txcount_16", v, 32'd16);

      // Push while full with simultaneous pop.
      do_reset();
      for (int i = 0; i < 16; i++) wr(32'h4000_0000, 32'h80 + 32'(i));
      tx_ready = 1'b1;
      wr(32'h4000_0000, 32'h55);
      tx_ready = 1'b0;
      rd(32'h4000_0004, v);
      check("full_pop_status", v, 32'h0000_1002);
      tx_ready = 1'b1;
      idle_steps(15);
      check("last_55", 32'(tx_data), 32'h55);
      idle_steps(1);
      tx_ready = 1'b0;

      // CTRL clear-overflow plus flush.
      do_reset();
      for (int i = 0; i < 17; i++) wr(32'h4000_0000, 32'(i));
      tx_ready = 1'b1;
      idle_steps(11);
      tx_ready = 1'b0;
      rd(32'h4000_0004, v);
      check("pre_ctrl_status", v, 32'h0000_0504);
      wr(32'h4000_0008, 32'h3);
      rd(32'h4000_0004, v);
      check("post_ctrl_status", v, 32'h0000_0001);

      // Asynchronous reset mid-drain.
      for (int i = 0; i < 5; i++) wr(32'h4000_0000, 32'hA0 + 32'(i));
      tx_ready = 1'b1;
      idle_steps(2);
      check("mid_drain_valid", 32'(tx_valid), 32'h1);
      do_reset();
      rd(32'h4000_000C, v);
      check("txcount_after_rst", v, 32'h0);

`ifdef PINWHEEL_CONSOLE_CRLF_EN
      // CRLF expansion needs two free slots.
      for (int i = 0; i < 15; i++) wr(32'h4000_0000, 32'(i));
      wr(32'h4000_0000, 32'h0A);
      rd(32'h4000_0004, v);
      check("crlf_no_room", v, 32'h0000_0F04);
      do_reset();
      wr(32'h4000_0000, 32'h0A);
      check("crlf_cr", 32'(tx_data), 32'h0D);
      tx_ready = 1'b1;
      idle_steps(1);
      check("crlf_lf", 32'(tx_data), 32'h0A);
      idle_steps(1);
      tx_ready = 1'b0;
`endif

      // Randomized traffic.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int unsigned op;
         logic [3:0]  tag;
         logic [1:0]  idx;
         logic [31:0] d;
         if (c % 200 == 0) tx_ready = 1'b0;
         tx_ready = ($urandom_range(0, 99) < ((c / 200) % 2 == 0 ? 20 : 70));
         tag = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'h4;
         op  = $urandom_range(0, 99);
         idle();
         if (op < 45) begin
            idx = 2'd0;
         end else if (op < 55) begin
            idx = 2'd2;
         end else if (op < 60) begin
            idx = 2'd3;
         end else begin
            idx = 2'($urandom_range(0, 3));
         end
         d = $urandom;
         if (idx == 2'd0 && $urandom_range(0, 9) == 0) d[7:0] = 8'h0A;
         if (idx == 2'd2) d[1] = ($urandom_range(0, 15) == 0);
         bus_addr  = {tag, 24'($urandom), idx, 2'($urandom)};
         bus_wdata = d;
         bus_wmask = 4'($urandom);
         if (op < 60 && $urandom_range(0, 3) != 0) begin
            bus_wren = 1'b1;
            bus_rden = ($urandom_range(0, 3) == 0);
         end else begin
            bus_rden = ($urandom_range(0, 1) == 0);
         end
         step();
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
